// File: rtl/multi_timer_controller_pkg.sv
// Shared constants and types for the multi-channel timer peripheral.
package multi_timer_controller_pkg;

  // Femto bus geometry and access-size encoding
  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Default timer configuration
  localparam int unsigned TMR_DIV = 4;
  localparam int unsigned TMR_CH  = 4;
  localparam int unsigned TMR_AW  = 6;

  // Word offsets inside a 16-byte channel window (addr[3:2])
  localparam logic [1:0] TMR_CNT = 2'd0;
  localparam logic [1:0] TMR_RLD = 2'd1;
  localparam logic [1:0] TMR_CSR = 2'd2;

  // CSR bit positions
  localparam int unsigned CSR_INTEN    = 7;
  localparam int unsigned CSR_PERIODIC = 6;
  localparam int unsigned CSR_PEND     = 0;

  // CSR readback image; reserved fields always read zero
  typedef struct packed {
    logic [23:0] rsv_hi;
    logic        inten;
    logic        periodic;
    logic [4:0]  rsv_lo;
    logic        pend;
  } tmr_csr_t;

endpackage

// File: rtl/multi_timer_controller_channel.sv
// One timer channel: prescaler, down-counter, reload and CSR flags.
module multi_timer_controller_channel
  import multi_timer_controller_pkg::*;
#(
  parameter int unsigned DIV = TMR_DIV
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cnt_we,
  input  logic                 rld_we,
  input  logic                 csr_we,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] cnt_rd,
  output logic [BUS_WIDTH-1:0] rld_rd,
  output tmr_csr_t             csr_rd,
  output logic                 pend,
  output logic                 inten
);

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV - 1);

  logic [BUS_WIDTH-1:0] cnt;
  logic [BUS_WIDTH-1:0] rld;
  logic [DW-1:0]        div;
  logic                 periodic;
  logic                 tick;
  logic                 expire;

  // A tick is a prescaler wrap while the counter is live; a CNT write masks expiry
  assign tick   = (cnt != '0) && (div == '0);
  assign expire = tick && (cnt == BUS_WIDTH'(1)) && !cnt_we;

  // Prescaler and counter; a CNT write takes priority over any tick
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      div <= '0;
    end else if (cnt_we) begin
      cnt <= wdata;
      div <= DIV_LOAD;
    end else if (tick) begin
      div <= DIV_LOAD;
      if (cnt == BUS_WIDTH'(1)) begin
        cnt <= (periodic && (rld != '0)) ? rld : '0;
      end else begin
        cnt <= cnt - BUS_WIDTH'(1);
      end
    end else if (cnt != '0) begin
      div <= div - DW'(1);
    end
  end

  // Reload value, only consumed at the next expiry
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rld <= '0;
    end else if (rld_we) begin
      rld <= wdata;
    end
  end

  // Control flags; expiry set beats a simultaneous write-1-to-clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inten    <= 1'b0;
      periodic <= 1'b0;
      pend     <= 1'b0;
    end else begin
      if (csr_we) begin
        inten    <= wdata[CSR_INTEN];
        periodic <= wdata[CSR_PERIODIC];
      end
      if (expire) begin
        pend <= 1'b1;
      end else if (csr_we && wdata[CSR_PEND]) begin
        pend <= 1'b0;
      end
    end
  end

  // Readback images
  always_comb begin
    csr_rd          = '0;
    csr_rd.inten    = inten;
    csr_rd.periodic = periodic;
    csr_rd.pend     = pend;
  end

  assign cnt_rd = cnt;
  assign rld_rd = rld;

endmodule

// File: rtl/multi_timer_controller.sv
// Multi-channel timer peripheral: bus decode, fault, response, readback and interrupt.
module multi_timer_controller
  import multi_timer_controller_pkg::*;
#(
  parameter int unsigned CH  = TMR_CH,
  parameter int unsigned DIV = TMR_DIV,
  parameter int unsigned AW  = TMR_AW
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     interrupt,
  input  logic [AW-1:0]            addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     rdata,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault
);

  localparam int unsigned IW = (AW > 4) ? AW - 4 : 1;

  logic [IW-1:0]        ch_idx;
  logic [1:0]           reg_off;
  logic                 ch_ok;
  logic                 legal;
  logic                 acc_ok;
  logic [BUS_WIDTH-1:0] rd_mux;
  logic [BUS_WIDTH-1:0] cnt_rd [CH];
  logic [BUS_WIDTH-1:0] rld_rd [CH];
  tmr_csr_t             csr_rd [CH];
  logic [CH-1:0]        pend;
  logic [CH-1:0]        inten;

  // Channel index comes from the bits above the 16-byte window
  if (AW > 4) begin : g_idx
    assign ch_idx = addr[AW-1:4];
  end else begin : g_idx_one
    assign ch_idx = '0;
  end

  assign reg_off = addr[3:2];
  assign acc_ok  = (acc == BUS_ACC_4B);

  // Channel present check
  always_comb begin
    ch_ok = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      if (ch_idx == IW'(i)) ch_ok = 1'b1;
    end
  end

  assign legal = (addr[1:0] == 2'b00) && acc_ok && (reg_off != 2'd3) && ch_ok;
  assign fault = req && !legal;

  // Channel instances with per-register write strobes
  for (genvar g = 0; g < int'(CH); g++) begin : g_ch
    logic wr_sel;
    assign wr_sel = req && legal && w_rb && (ch_idx == IW'(g));

    multi_timer_controller_channel #(
      .DIV (DIV)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .cnt_we (wr_sel && (reg_off == TMR_CNT)),
      .rld_we (wr_sel && (reg_off == TMR_RLD)),
      .csr_we (wr_sel && (reg_off == TMR_CSR)),
      .wdata  (wdata),
      .cnt_rd (cnt_rd[g]),
      .rld_rd (rld_rd[g]),
      .csr_rd (csr_rd[g]),
      .pend   (pend[g]),
      .inten  (inten[g])
    );
  end

  // Readback selection
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (ch_idx == IW'(i)) begin
        case (reg_off)
          TMR_CNT: rd_mux = cnt_rd[i];
          TMR_RLD: rd_mux = rld_rd[i];
          TMR_CSR: rd_mux = csr_rd[i];
          default: ;
        endcase
      end
    end
  end

  // Response and read data, one cycle after a legal request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      resp <= req && legal;
      if (req && legal && !w_rb) rdata <= rd_mux;
    end
  end

  assign interrupt = |(pend & inten);

endmodule

// File: tb/tb_multi_timer_controller.sv
// Scoreboard bench for multi_timer_controller (CH=4, DIV=4, AW=7).
module tb_multi_timer_controller;
  import multi_timer_controller_pkg::*;

  localparam int unsigned CH  = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned AW  = 7;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     interrupt;
  logic [AW-1:0]            addr = '0;
  logic                     w_rb = 1'b0;
  logic [BUS_ACC_WIDTH-1:0] acc = BUS_ACC_4B;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [BUS_WIDTH-1:0]     wdata = '0;
  logic                     req = 1'b0;
  logic                     resp;
  logic                     fault;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [31:0] exp_q [$];
  bit          rd_q  [$];
  string       tag_q [$];

  logic [31:0] e_v;
  bit          r_v;
  string       tg_v;
  int unsigned t0, t1, t_irq;

  multi_timer_controller #(
    .CH  (CH),
    .DIV (DIV),
    .AW  (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .interrupt (interrupt),
    .addr      (addr),
    .w_rb      (w_rb),
    .acc       (acc),
    .rdata     (rdata),
    .wdata     (wdata),
    .req       (req),
    .resp      (resp),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: every resp pops one entry; reads compare rdata
  always @(negedge clk) begin
    if (resp) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(resp), 32'd0);
      end else begin
        e_v  = exp_q.pop_front();
        r_v  = rd_q.pop_front();
        tg_v = tag_q.pop_front();
        if (r_v) chk(tg_v, rdata, e_v);
      end
    end
  end

  // All bus tasks start and end 1 time unit after a rising edge
  task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] d);
    req = 1'b1; w_rb = 1'b1; acc = BUS_ACC_4B; addr = a; wdata = d;
    #1 chk("wr_fault", 32'(fault), 32'd0);
    exp_q.push_back(32'd0); rd_q.push_back(1'b0); tag_q.push_back("wr");
    @(posedge clk); #1;
    req = 1'b0; w_rb = 1'b0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    req = 1'b1; w_rb = 1'b0; acc = BUS_ACC_4B; addr = a;
    #1 chk("rd_fault", 32'(fault), 32'd0);
    exp_q.push_back(exp); rd_q.push_back(1'b1); tag_q.push_back(tag);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic bus_bad(input logic [AW-1:0] a, input logic [1:0] ac, input logic wr,
                         input logic [31:0] d, input string tag);
    req = 1'b1; w_rb = wr; acc = ac; addr = a; wdata = d;
    #1 chk(tag, 32'(fault), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; w_rb = 1'b0; acc = BUS_ACC_4B;
    chk("bad_no_resp", 32'(resp), 32'd0);
  endtask

  // Advance so that the next bus access is captured at edge 'target'
  task automatic wait_until(input int unsigned target);
    while (cyc + 1 < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_irq(input int bound, output int unsigned at);
    for (int i = 0; i < bound; i++) begin
      if (interrupt) break;
      @(posedge clk); #1;
    end
    if (!interrupt) chk("irq_timeout", 32'(interrupt), 32'd1);
    at = cyc;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    bus_rd(7'h00, 32'd0, "rst_cnt0");
    bus_rd(7'h18, 32'd0, "rst_csr1");
    bus_rd(7'h34, 32'd0, "rst_rld3");

    // One-shot ch0: expiry 3*DIV after the write edge
    bus_wr(7'h08, 32'h80);
    bus_wr(7'h00, 32'd3);
    t0 = cyc;
    wait_irq(40, t_irq);
    chk("ch0_expiry_dt", t_irq - t0, 32'd12);
    bus_rd(7'h00, 32'd0, "ch0_cnt_after");
    bus_rd(7'h08, 32'h81, "ch0_csr_pend");
    bus_wr(7'h08, 32'h81);
    chk("ch0_irq_w1c", 32'(interrupt), 32'd0);
    bus_wr(7'h08, 32'h00);

    // Periodic ch2: expiries every RLD*DIV cycles without slip
    bus_wr(7'h24, 32'd2);
    bus_wr(7'h28, 32'hC0);
    bus_wr(7'h20, 32'd2);
    t0 = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_irq(40, t_irq);
      chk("ch2_period", t_irq - t0, 32'(8 * k));
      bus_wr(7'h28, 32'hC1);
      chk("ch2_irq_w1c", 32'(interrupt), 32'd0);
      bus_rd(7'h20, 32'd2, "ch2_cnt_reloaded");
    end
    bus_wr(7'h20, 32'd0);
    bus_wr(7'h28, 32'h01);

    // ch1: CNT write on the expiry edge wins
    bus_wr(7'h18, 32'h80);
    bus_wr(7'h10, 32'd1);
    t1 = cyc;
    wait_until(t1 + 4);
    bus_wr(7'h10, 32'd5);
    chk("ch1_ww_irq", 32'(interrupt), 32'd0);
    bus_rd(7'h18, 32'h80, "ch1_pend_stays0");
    wait_irq(60, t_irq);
    chk("ch1_expiry_dt", t_irq - (t1 + 4), 32'd20);
    bus_wr(7'h18, 32'h01);

    // ch3: W1C coinciding with expiry, set wins
    bus_wr(7'h38, 32'h80);
    bus_wr(7'h30, 32'd2);
    t0 = cyc;
    wait_until(t0 + 8);
    bus_wr(7'h38, 32'h81);
    chk("ch3_irq_kept", 32'(interrupt), 32'd1);
    bus_rd(7'h38, 32'h81, "ch3_pend_set_wins");
    bus_wr(7'h38, 32'h81);
    chk("ch3_irq_clr", 32'(interrupt), 32'd0);

    // ch3: clearing PERIODIC on the expiry edge still reloads
    bus_wr(7'h34, 32'd3);
    bus_wr(7'h38, 32'h40);
    bus_wr(7'h30, 32'd1);
    t0 = cyc;
    wait_until(t0 + 4);
    bus_wr(7'h38, 32'h00);
    bus_rd(7'h30, 32'd3, "ch3_reload_prewrite");
    bus_rd(7'h38, 32'h01, "ch3_csr_after");
    bus_wr(7'h30, 32'd0);
    bus_wr(7'h38, 32'h01);

    // Illegal accesses: fault, no resp, no state change
    bus_wr(7'h04, 32'h55);
    bus_bad(7'h02, BUS_ACC_4B, 1'b1, 32'h1234, "f_misalign");
    bus_bad(7'h04, 2'd1,       1'b1, 32'h99,   "f_acc2b");
    bus_bad(7'h0C, BUS_ACC_4B, 1'b1, 32'h77,   "f_rsvd");
    bus_bad(7'h40, BUS_ACC_4B, 1'b1, 32'h66,   "f_ch4");
    bus_rd(7'h00, 32'd0, "f_cnt0");
    bus_rd(7'h04, 32'h55, "f_rld0");
    bus_rd(7'h08, 32'h00, "f_csr0");
    bus_rd(7'h04, 32'h55, "f_rld0_again");
    bus_bad(7'h46, BUS_ACC_4B, 1'b0, 32'h0, "f_rd_ch4");
    chk("f_rdata_hold", rdata, 32'h55);

    // Reset mid-count
    bus_wr(7'h08, 32'h80);
    bus_wr(7'h00, 32'd100);
    bus_rd(7'h00, 32'd100, "pre_rst_cnt0");
    bus_wr(7'h18, 32'h80);
    bus_wr(7'h10, 32'd1);
    t0 = cyc;
    wait_irq(20, t_irq);
    chk("pre_rst_irq_dt", t_irq - t0, 32'd4);
    rstn = 1'b0; req = 1'b1; w_rb = 1'b0; addr = 7'h00; acc = BUS_ACC_4B;
    @(posedge clk); #1;
    req = 1'b0;
    chk("mid_rst_resp", 32'(resp), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_irq", 32'(interrupt), 32'd0);
    rstn = 1'b1;
    bus_rd(7'h00, 32'd0, "post_rst_cnt0");
    bus_rd(7'h08, 32'd0, "post_rst_csr0");
    bus_rd(7'h18, 32'd0, "post_rst_csr1");
    repeat (10) @(posedge clk);
    #1;
    bus_rd(7'h00, 32'd0, "post_rst_cnt0_idle");
    chk("post_rst_irq", 32'(interrupt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
